// File: rtl/pattern_det_pkg.sv
// Shared types and helpers for the pattern_det serial pattern detector.
package pattern_det_pkg;

    // Largest supported pattern length.
    localparam int PAT_W_MAX = 32;

    // Detector FSM states: FILL while the window is still collecting bits,
    // ARMED once every valid bit completes a full window.
    typedef enum logic [0:0] {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    // Width needed to count 0..pat_w filled window positions.
    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/pattern_det_window.sv
// Sliding history window and fill counter for pattern_det.
// window[0] is the newest bit; full_next tells the compare logic that the
// window will hold PAT_W fresh bits once the current bit is shifted in.
module pattern_det_window
    import pattern_det_pkg::*;
#(
    parameter int PAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             data_bit,
    input  logic             flush,
    output logic [PAT_W-1:0] window,
    output logic [PAT_W-1:0] next_window,
    output logic             full_next
);

    localparam int               FW       = fill_w(PAT_W);
    localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W);
    localparam logic [FW-1:0]    FILL_ONE = FW'(1'b1);

    logic [PAT_W-1:0] window_r;
    logic [FW-1:0]    fill_r;

    // Window contents after shifting in the current bit.
    if (PAT_W == 1) begin : g_single
        assign next_window = data_bit;
    end else begin : g_multi
        assign next_window = {window_r[PAT_W-2:0], data_bit};
    end

    // The shift completes (or keeps) a full window when at most one bit is missing.
    always_comb begin
        full_next = 1'b0;
        if (shift && (fill_r >= (FILL_MAX - FILL_ONE))) begin
            full_next = 1'b1;
        end else begin
            full_next = 1'b0;
        end
    end

    // History register and saturating fill count; flush restarts collection.
    always_ff @(posedge clk) begin
        if (rst) begin
            window_r <= '0;
            fill_r   <= '0;
        end else if (flush) begin
            window_r <= '0;
            fill_r   <= '0;
        end else if (shift) begin
            window_r <= next_window;
            if (fill_r != FILL_MAX) begin
                fill_r <= fill_r + FILL_ONE;
            end
        end
    end

    assign window = window_r;

endmodule

// File: rtl/pattern_det.sv
// Parametrised serial bit-pattern detector with runtime-loadable pattern,
// don't-care mask and overlapping / non-overlapping match modes.
// Optional saturating detection counter: define PATDET_COUNT_EN.
module pattern_det
    import pattern_det_pkg::*;
#(
    parameter int               PAT_W       = 3,
    parameter logic [PAT_W-1:0] DEF_PATTERN = '0,
    parameter logic [PAT_W-1:0] DEF_MASK    = '1,
    parameter int               DCNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              din_valid,
    input  logic              cfg_load,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [PAT_W-1:0]  cfg_mask,
    input  logic              cfg_overlap,
`ifdef PATDET_COUNT_EN
    output logic [DCNT_W-1:0] det_count,
`endif
    output logic              detected
);

    if ((PAT_W < 1) || (PAT_W > PAT_W_MAX) || (DCNT_W < 1)) begin : g_param_check
        $error("pattern_det: PAT_W or DCNT_W out of range");
    end

    state_t           state_r;
    state_t           state_nxt_s;
    logic [PAT_W-1:0] pattern_r;
    logic [PAT_W-1:0] mask_r;
    logic             overlap_r;
    logic             shift_s;
    logic             flush_s;
    logic             restart_s;
    logic             cmp_s;
    logic             match_s;
    logic             full_next_s;
    logic [PAT_W-1:0] next_window_s;
    logic [PAT_W-1:0] window_unused_s;  // current window, not needed here

    // A load discards the bit presented alongside it.
    assign shift_s = din_valid & ~cfg_load;
    assign flush_s = cfg_load | restart_s;

    pattern_det_window #(
        .PAT_W (PAT_W)
    ) u_window (
        .clk         (clk),
        .rst         (rst),
        .shift       (shift_s),
        .data_bit    (din),
        .flush       (flush_s),
        .window      (window_unused_s),
        .next_window (next_window_s),
        .full_next   (full_next_s)
    );

    // Masked compare of the window including the current bit.
    always_comb begin
        cmp_s = 1'b0;
        if (((next_window_s ^ pattern_r) & mask_r) == '0) begin
            cmp_s = 1'b1;
        end else begin
            cmp_s = 1'b0;
        end
    end

    // Next state, match qualification and non-overlap restart.
    always_comb begin
        state_nxt_s = state_r;
        match_s     = 1'b0;
        restart_s   = 1'b0;
        case (state_r)
            FILL: begin
                if (full_next_s) begin
                    match_s = cmp_s;
                    if (cmp_s && !overlap_r) begin
                        restart_s   = 1'b1;
                        state_nxt_s = FILL;
                    end else begin
                        state_nxt_s = ARMED;
                    end
                end else begin
                    state_nxt_s = FILL;
                end
            end
            ARMED: begin
                if (shift_s) begin
                    match_s = cmp_s;
                    if (cmp_s && !overlap_r) begin
                        restart_s   = 1'b1;
                        state_nxt_s = FILL;
                    end else begin
                        state_nxt_s = ARMED;
                    end
                end else begin
                    state_nxt_s = ARMED;
                end
            end
            default: begin
                state_nxt_s = FILL;
            end
        endcase
        if (cfg_load) begin
            state_nxt_s = FILL;
            match_s     = 1'b0;
            restart_s   = 1'b0;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State, configuration and registered match pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= FILL;
            pattern_r <= DEF_PATTERN;
            mask_r    <= DEF_MASK;
            overlap_r <= 1'b1;
            detected  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            detected <= match_s;
            if (cfg_load) begin
                pattern_r <= cfg_pattern;
                mask_r    <= cfg_mask;
                overlap_r <= cfg_overlap;
            end
        end
    end

`ifdef PATDET_COUNT_EN
    logic [DCNT_W-1:0] count_r;

    // Saturating detection counter, cleared on reset and configuration load.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (cfg_load) begin
            count_r <= '0;
        end else if (match_s && (count_r != {DCNT_W{1'b1}})) begin
            count_r <= count_r + {{(DCNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign det_count = count_r;
`endif

endmodule

// File: tb/tb_pattern_det.sv
// Self-checking bench for pattern_det (PAT_W=3, DCNT_W=2): directed vector
// table, hand-written counter/all-zero-mask sequences and a randomized run
// against a queue-based reference model.
module tb_pattern_det;

    localparam int PAT_W  = 3;
    localparam int DCNT_W = 2;
    localparam int CMAX   = (1 << DCNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             din = 1'b0;
    logic             din_valid = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [PAT_W-1:0] cfg_mask = '0;
    logic             cfg_overlap = 1'b0;
    logic             detected;
`ifdef PATDET_COUNT_EN
    logic [DCNT_W-1:0] det_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pattern_det #(
        .PAT_W       (PAT_W),
        .DEF_PATTERN (3'b000),
        .DEF_MASK    (3'b111),
        .DCNT_W      (DCNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .cfg_overlap (cfg_overlap),
`ifdef PATDET_COUNT_EN
        .det_count   (det_count),
`endif
        .detected    (detected)
    );

    // ---------------- reference model ----------------
    bit               hist[$];
    logic [PAT_W-1:0] m_pat;
    logic [PAT_W-1:0] m_mask;
    bit               m_ovl;
    int               m_cnt;

    task automatic model_step(input logic r, input logic ld, input logic [PAT_W-1:0] p,
                              input logic [PAT_W-1:0] m, input logic o, input logic v,
                              input logic b, output bit hit);
        hit = 1'b0;
        if (r) begin
            hist.delete();
            m_pat = 3'b000; m_mask = 3'b111; m_ovl = 1'b1; m_cnt = 0;
        end else if (ld) begin
            hist.delete();
            m_pat = p; m_mask = m; m_ovl = o; m_cnt = 0;
        end else if (v) begin
            hist.push_back(b);
            if (hist.size() > PAT_W) void'(hist.pop_front());
            if (hist.size() == PAT_W) begin
                hit = 1'b1;
                for (int i = 0; i < PAT_W; i++) begin
                    // hist[0] is the oldest bit, which lines up with the pattern MSB
                    if (m_mask[PAT_W-1-i] && (hist[i] != m_pat[PAT_W-1-i])) hit = 1'b0;
                end
                if (hit) begin
                    if (m_cnt < CMAX) m_cnt++;
                    if (!m_ovl) hist.delete();
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, and wait past the edge.
    task automatic apply(input logic r, input logic ld, input logic [PAT_W-1:0] p,
                         input logic [PAT_W-1:0] m, input logic o, input logic v,
                         input logic b, output bit exp_det);
        rst = r; cfg_load = ld; cfg_pattern = p; cfg_mask = m; cfg_overlap = o;
        din_valid = v; din = b;
        model_step(r, ld, p, m, o, v, b, exp_det);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic             r;
        logic             ld;
        logic [PAT_W-1:0] p;
        logic [PAT_W-1:0] m;
        logic             o;
        logic             v;
        logic             b;
        logic             ed;
        bit               cc;
        int               ec;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic ld, input logic [PAT_W-1:0] p,
                                input logic [PAT_W-1:0] m, input logic o, input logic v,
                                input logic b, input logic ed, input bit cc, input int ec);
        vec_t t;
        t.r = r; t.ld = ld; t.p = p; t.m = m; t.o = o; t.v = v; t.b = b;
        t.ed = ed; t.cc = cc; t.ec = ec;
        vecs.push_back(t);
    endfunction

    function automatic void add_bit(input logic b, input logic ed);
        add(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, b, ed, 1'b0, 0);
    endfunction

    function automatic void add_idle();
        add(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    endfunction

    function automatic void add_load(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m,
                                     input logic o);
        add(1'b0, 1'b1, p, m, o, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    endfunction

    initial begin
        bit exp_d;
        int pulses;

        // 1: reset defaults, overlapping 000
        add(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        add(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        add_bit(1'b0, 1'b0); add_bit(1'b0, 1'b0); add_bit(1'b0, 1'b1); add_bit(1'b0, 1'b1);
        add_bit(1'b1, 1'b0); add_bit(1'b0, 1'b0); add_bit(1'b0, 1'b0);
        add(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3);
        // 2: non-overlapping 100, then non-overlapping 000
        add_load(3'b100, 3'b111, 1'b0);
        add_bit(1'b1, 1'b0); add_bit(1'b0, 1'b0); add_bit(1'b0, 1'b1);
        add_bit(1'b1, 1'b0); add_bit(1'b0, 1'b0); add_bit(1'b0, 1'b1);
        add_load(3'b000, 3'b111, 1'b0);
        add_bit(1'b0, 1'b0); add_bit(1'b0, 1'b0); add_bit(1'b0, 1'b1);
        add_bit(1'b0, 1'b0); add_bit(1'b0, 1'b0);
        // 3: don't-care mask 101/101
        add_load(3'b101, 3'b101, 1'b1);
        add_bit(1'b1, 1'b0); add_bit(1'b1, 1'b0); add_bit(1'b1, 1'b1);
        add_load(3'b101, 3'b101, 1'b1);
        add_bit(1'b1, 1'b0); add_bit(1'b0, 1'b0); add_bit(1'b0, 1'b0);
        // 4: valid gaps
        add_load(3'b100, 3'b111, 1'b1);
        add_bit(1'b1, 1'b0); add_idle(); add_idle();
        add_bit(1'b0, 1'b0); add_idle(); add_idle();
        add_bit(1'b0, 1'b1); add_idle(); add_idle();
        // 5a: load collides with the final matching bit
        add_load(3'b100, 3'b111, 1'b1);
        add_bit(1'b1, 1'b0); add_bit(1'b0, 1'b0);
        add(1'b0, 1'b1, 3'b100, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        add_idle();
        add_bit(1'b1, 1'b0); add_bit(1'b0, 1'b0); add_bit(1'b0, 1'b1);
        // 5b: reset after 2 of 3 bits; defaults (000) return afterwards
        add_load(3'b100, 3'b111, 1'b1);
        add_bit(1'b1, 1'b0); add_bit(1'b0, 1'b0);
        add(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        add_bit(1'b0, 1'b0); add_bit(1'b0, 1'b0); add_bit(1'b0, 1'b1);
        // all-zero mask, non-overlapping: one hit every 3 valid bits
        add_load(3'b010, 3'b000, 1'b0);
        add_bit(1'b1, 1'b0); add_bit(1'b0, 1'b0); add_bit(1'b1, 1'b1);
        add_bit(1'b1, 1'b0); add_bit(1'b1, 1'b0); add_bit(1'b0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].r, vecs[i].ld, vecs[i].p, vecs[i].m, vecs[i].o,
                  vecs[i].v, vecs[i].b, exp_d);
            check($sformatf("vec%0d detected", i), {31'd0, detected}, {31'd0, vecs[i].ed});
`ifdef PATDET_COUNT_EN
            if (vecs[i].cc) begin
                check($sformatf("vec%0d det_count", i), {30'd0, det_count}, vecs[i].ec);
            end
`endif
        end

        // 6: counter saturation with an all-zero mask in overlapping mode
        apply(1'b0, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, exp_d);
        pulses = 0;
        for (int k = 0; k < 7; k++) begin
            apply(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'($urandom_range(0, 1)), exp_d);
            if (detected) pulses++;
            check($sformatf("sat bit%0d detected", k), {31'd0, detected}, (k >= 2) ? 32'd1 : 32'd0);
`ifdef PATDET_COUNT_EN
            check($sformatf("sat bit%0d det_count", k), {30'd0, det_count},
                  (k < 2) ? 32'd0 : ((k - 1 > 3) ? 32'd3 : 32'(k - 1)));
`endif
        end
        check("sat pulse total", pulses, 32'd5);

        // randomized run against the reference model
        apply(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, exp_d);
        for (int c = 0; c < 3000; c++) begin
            logic r_r, r_ld, r_v;
            r_r  = ($urandom_range(0, 199) == 0);
            r_ld = ($urandom_range(0, 39) == 0);
            r_v  = ($urandom_range(0, 9) < 7);
            apply(r_r, r_ld, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), r_v, 1'($urandom_range(0, 1)), exp_d);
            check($sformatf("rnd%0d detected", c), {31'd0, detected}, {31'd0, exp_d});
`ifdef PATDET_COUNT_EN
            check($sformatf("rnd%0d det_count", c), {30'd0, det_count}, m_cnt);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
